// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: the sequencer drives the controls, the counter reports state.
`timescale 1ns/1ps
interface mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;

    modport master (
        output en, dir, load, d, oneshot,
        input  q, tc, done
    );

    modport slave (
        input  en, dir, load, d, oneshot,
        output q, tc, done
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with load, terminal-count pulse and one-shot stop.
// Optional clock-enable prescaler is built only when MOD_COUNTER_PRESCALE_EN is defined.
`timescale 1ns/1ps
module mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1
) (
    input logic           clk,
    input logic           rst,
    mod_counter_if.slave  bus
);

    typedef enum logic {StRun, StStop} state_e;

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || PRESCALE < 1) begin : g_bad_params
        $error("mod_counter: illegal MODULUS/PRESCALE for given WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    state_e           state_q, state_d;
    logic             step;
    logic             at_term;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int unsigned     PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsWidth-1:0] PsLast = PsWidth'(PRESCALE - 1);

    logic [PsWidth-1:0] ps_q, ps_d;

    always_comb begin
        ps_d = ps_q;
        if (bus.load) begin
            ps_d = '0;
        end else if (bus.en) begin
            ps_d = (ps_q == PsLast) ? '0 : ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step = bus.en & (ps_q == PsLast);
`else
    assign step = bus.en;
`endif

    assign at_term = bus.dir ? (q_q == MaxVal) : (q_q == '0);

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        if (bus.load) begin
            q_d     = (bus.d > MaxVal) ? MaxVal : bus.d;
            state_d = StRun;
        end else if (state_q == StRun && step) begin
            if (at_term && bus.oneshot) begin
                state_d = StStop;
            end else if (bus.dir) begin
                q_d = at_term ? '0 : q_q + 1'b1;
            end else begin
                q_d = at_term ? MaxVal : q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q     <= '0;
            state_q <= StRun;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
        end
    end

    // rst gates tc because q is forced to 0, which is terminal when counting down.
    assign bus.tc   = rst & ~bus.load & step & at_term & (state_q == StRun);
    assign bus.q    = q_q;
    assign bus.done = (state_q == StStop);

endmodule
